// File: rtl/mux_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mux_scanner
// Purpose  : Steps the select lines of an external 8:1 multiplexer through
//            channels 0..7, waits SETTLE_CYC cycles after each select change,
//            samples the mux output y and assembles the eight samples into a
//            result word. The word is held with valid=1 until acknowledged.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE_CYC  settle cycles after each select change (legal 1..15)
// Ports
//   clk         clock, all state updates on its rising edge
//   rst         synchronous active-high reset
//   start       request one scan; honoured only when idle
//   y           output of the scanned 8:1 multiplexer
//   ack         consumer acknowledge of the result word
//   s0,s1,s2    multiplexer select (s2 = MSB)
//   data[7:0]   result word, bit k = y sampled while select was k
//   valid       data holds a complete scan result
//   busy        scan in progress or result awaiting ack
// Build option
//   MSCAN_CONT_EN  when defined, ack restarts the scan immediately (continuous
//                  scanning); only rst returns the block to idle.
// ============================================================================
module mux_scanner #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  input  logic       ack,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last settle count value before moving on to the sample cycle.
  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYC - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_sel,   w_sel_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  logic [7:0] r_sh,    w_sh_nxt;
  logic [7:0] r_data,  w_data_nxt;
  logic       r_valid, w_valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= 4'd0;
      r_sh    <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_sel_nxt   = 3'd0;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == c_settle_last) begin
          w_state_nxt = SAMPLE;
        end
      end

      SAMPLE: begin
        w_sh_nxt[r_sel] = y;
        if (r_sel != 3'd7) begin
          w_sel_nxt   = r_sel + 3'd1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = SETTLE;
        end else begin
          // The channel-7 sample is taken straight from y because the shadow
          // register only picks it up on this same edge.
          w_data_nxt  = {y, r_sh[6:0]};
          w_valid_nxt = 1'b1;
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        // A start arriving together with ack is deliberately dropped.
        if (ack) begin
          w_valid_nxt = 1'b0;
          w_sel_nxt   = 3'd0;
`ifdef MSCAN_CONT_EN
          w_cnt_nxt   = 4'd0;
          w_state_nxt = SETTLE;
`else
          w_state_nxt = IDLE;
`endif
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign s0    = r_sel[0];
  assign s1    = r_sel[1];
  assign s2    = r_sel[2];
  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scanner
// Purpose  : Self-checking bench for mux_scanner. Two instances are used:
//            dut_a with SETTLE_CYC=2 and dut_b with SETTLE_CYC=1, each driven
//            by a behavioural 8:1 mux model. Stimulus pushes the expected word
//            and valid-rise cycle into a queue; a monitor per instance pops
//            and compares whenever valid rises. The continuous-scan sequence
//            is selected by MSCAN_CONT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scanner;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       start_a, ack_a, y_a, s0_a, s1_a, s2_a, valid_a, busy_a;
  logic [7:0] data_a, mux_a;
  logic [2:0] sel_a;
  logic       start_b, ack_b, y_b, s0_b, s1_b, s2_b, valid_b, busy_b;
  logic [7:0] data_b, mux_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  logic       rst_at_edge = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Behavioural 8:1 multiplexers being scanned.
  assign y_a   = mux_a[{s2_a, s1_a, s0_a}];
  assign y_b   = mux_b[{s2_b, s1_b, s0_b}];
  assign sel_a = {s2_a, s1_a, s0_a};

  mux_scanner #(.SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .y(y_a), .ack(ack_a),
    .s0(s0_a), .s1(s1_a), .s2(s2_a), .data(data_a), .valid(valid_a), .busy(busy_a)
  );

  mux_scanner #(.SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .y(y_b), .ack(ack_b),
    .s0(s0_b), .s1(s1_b), .s2(s2_b), .data(data_b), .valid(valid_b), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid_a(input int lim, input bit busy_held);
    int n = 0;
    while (!valid_a && n < lim) begin
      if (busy_held) chk("busy_held_a", int'(busy_a), 1);
      tick();
      n++;
    end
    chk("valid_a_reached", int'(valid_a), 1);
  endtask

  task automatic wait_valid_b(input int lim);
    int n = 0;
    while (!valid_b && n < lim) begin
      tick();
      n++;
    end
    chk("valid_b_reached", int'(valid_b), 1);
  endtask

  // Monitor for dut_a: word/latency on valid rise, data stability otherwise.
  logic       pv_a = 1'b0;
  logic [7:0] pd_a = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (valid_a && !pv_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_a actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = q_a.pop_front();
          chk("word_a", int'(data_a), int'(e.d));
          chk("latency_a", cyc, e.c);
          chk("busy_at_valid_a", int'(busy_a), 1);
        end
      end else if (!rst_at_edge) begin
        chk("data_stable_a", int'(data_a), int'(pd_a));
      end
      pv_a = valid_a;
      pd_a = data_a;
    end
  end

  logic       pv_b = 1'b0;
  logic [7:0] pd_b = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (valid_b && !pv_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_b actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = q_b.pop_front();
          chk("word_b", int'(data_b), int'(e.d));
          chk("latency_b", cyc, e.c);
        end
      end else if (!rst_at_edge) begin
        chk("data_stable_b", int'(data_b), int'(pd_b));
      end
      pv_b = valid_b;
      pd_b = data_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    start_a = 1'b0; ack_a = 1'b0; mux_a = 8'h00;
    start_b = 1'b0; ack_b = 1'b0; mux_b = 8'h00;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_sel_a", int'(sel_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_valid_a", int'(valid_a), 0);
    chk("rst_data_a", int'(data_a), 0);
    chk("rst_valid_b", int'(valid_b), 0);
    chk("rst_data_b", int'(data_b), 0);

    // SETTLE_CYC=1 instance: 16-edge scan of 8'h81
    mux_b = 8'h81;
    start_b = 1'b1;
    q_b.push_back('{d: 8'h81, c: cyc + 1 + 16});
    tick();
    start_b = 1'b0;
    wait_valid_b(40);

    // SETTLE_CYC=2 instance: 24-edge scan of 8'hA5 with select stepping
    mux_a = 8'hA5;
    start_a = 1'b1;
    q_a.push_back('{d: 8'hA5, c: cyc + 1 + 24});
    tick();
    start_a = 1'b0;
    for (int j = 0; j < 24; j++) begin
      chk("sel_step_a", int'(sel_a), j / 3);
      chk("busy_scan_a", int'(busy_a), 1);
      tick();
    end
    chk("valid_24_a", int'(valid_a), 1);
    chk("sel_end_a", int'(sel_a), 7);

    // Result held without ack
    for (int j = 0; j < 10; j++) begin
      chk("hold_valid_a", int'(valid_a), 1);
      chk("hold_data_a", int'(data_a), 8'hA5);
      tick();
    end

`ifdef MSCAN_CONT_EN
    // Continuous: ack restarts scanning, busy never drops
    mux_a = 8'h0F;
    ack_a = 1'b1;
    q_a.push_back('{d: 8'h0F, c: cyc + 1 + 24});
    tick();
    ack_a = 1'b0;
    chk("cont_valid_clr_a", int'(valid_a), 0);
    chk("cont_busy_a", int'(busy_a), 1);
    chk("cont_data_kept_a", int'(data_a), 8'hA5);
    wait_valid_a(40, 1'b1);
    mux_a = 8'hF0;
    ack_a = 1'b1;
    q_a.push_back('{d: 8'hF0, c: cyc + 1 + 24});
    tick();
    ack_a = 1'b0;
    wait_valid_a(40, 1'b1);
    chk("cont_word2_a", int'(data_a), 8'hF0);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
`else
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    chk("ack_valid_a", int'(valid_a), 0);
    chk("ack_busy_a", int'(busy_a), 0);
    chk("ack_sel_a", int'(sel_a), 0);
    chk("ack_data_a", int'(data_a), 8'hA5);
    tick();
    chk("idle_stays_a", int'(busy_a), 0);
    mux_a = 8'hA5;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
`endif

    // Reset mid-scan at select 4
    n = 0;
    while (sel_a != 3'd4 && n < 40) begin
      tick();
      n++;
    end
    chk("reach_sel4_a", int'(sel_a), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_sel_a", int'(sel_a), 0);
    chk("midrst_busy_a", int'(busy_a), 0);
    chk("midrst_valid_a", int'(valid_a), 0);
    chk("midrst_data_a", int'(data_a), 0);
    chk("midrst_valid_b", int'(valid_b), 0);

    // Start on the first edge after reset release
    mux_a = 8'h3C;
    start_a = 1'b1;
    q_a.push_back('{d: 8'h3C, c: cyc + 1 + 24});
    tick();
    start_a = 1'b0;
    wait_valid_a(40, 1'b0);

`ifndef MSCAN_CONT_EN
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;

    // start held through a scan, then start together with ack in DONE
    mux_a = 8'h5A;
    start_a = 1'b1;
    q_a.push_back('{d: 8'h5A, c: cyc + 1 + 24});
    tick();
    wait_valid_a(40, 1'b0);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    start_a = 1'b0;
    chk("start_ack_busy_a", int'(busy_a), 0);
    chk("start_ack_valid_a", int'(valid_a), 0);
    for (int j = 0; j < 5; j++) tick();
    chk("no_restart_busy_a", int'(busy_a), 0);
    chk("no_restart_sel_a", int'(sel_a), 0);
    mux_a = 8'hC3;
    start_a = 1'b1;
    q_a.push_back('{d: 8'hC3, c: cyc + 1 + 24});
    tick();
    start_a = 1'b0;
    wait_valid_a(40, 1'b0);
`endif

    tick();
    tick();
    chk("queue_empty_a", q_a.size(), 0);
    chk("queue_empty_b", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving the number of settle cycles after each select change before sampling; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request one 8-channel scan; honoured only in IDLE.
REQ-005 The block SHALL have port y, input, 1 bit: output of the downstream 8:1 multiplexer being scanned.
REQ-006 The block SHALL have port ack, input, 1 bit: consumer acknowledge of the result word.
REQ-007 The block SHALL have ports s0, s1, s2, output, 1 bit each: multiplexer select, with s2 as the MSB and s0 as the LSB.
REQ-008 The block SHALL have port data, output, 8 bits: the assembled word, with bit k equal to y sampled while the select was k.
REQ-009 The block SHALL have port valid, output, 1 bit: data holds a complete scan result.
REQ-010 The block SHALL have port busy, output, 1 bit: a scan is in progress or a result is awaiting ack.

Function
REQ-011 The block SHALL implement states IDLE, SETTLE, SAMPLE and DONE, using an internal 3-bit select counter sel, a settle counter cnt and an 8-bit shadow register sh.
REQ-012 In IDLE with start=1, the next edge SHALL set sel=0, cnt=0 and busy=1, and SHALL move to SETTLE; start=0 holds IDLE.
REQ-013 In SETTLE, each edge SHALL increment cnt; on the edge where cnt==SETTLE_CYC-1 the state SHALL become SAMPLE.
REQ-014 In SAMPLE, the edge SHALL write sh[sel]<=y; if sel<7 it SHALL set sel<=sel+1 and cnt<=0 and return to SETTLE; if sel==7 it SHALL load data<=sh with bit 7 replaced by y, set valid<=1 and move to DONE.
REQ-015 Each channel SHALL take exactly SETTLE_CYC+1 edges, and valid SHALL rise 8*(SETTLE_CYC+1) edges after the edge that accepted start (24 edges at default).
REQ-016 s2,s1,s0 SHALL equal sel at all times, and sel SHALL stay constant through SETTLE and SAMPLE for a given channel.
REQ-017 data SHALL change only on entry to DONE and SHALL be stable otherwise, including during subsequent scans.
REQ-018 In DONE, valid SHALL stay 1 until ack=1; the edge with ack=1 SHALL clear valid, clear busy, set sel=0 and return to IDLE.
REQ-019 ack outside DONE SHALL be ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 If start and ack are both 1 in DONE, the block SHALL go to IDLE and ignore that start; a new start is needed from the next cycle.
REQ-022 After sel reaches 7, the block SHALL not wrap sel within a scan; sel returns to 0 only via REQ-018 or reset.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE with sel=0, cnt=0, sh=0, data=8'h00, valid=0 and busy=0, overriding all other inputs, including mid-scan and in DONE.
REQ-024 After rst deasserts, the block SHALL accept start on the first edge.

Configuration
REQ-025 The block SHALL support the macro MSCAN_CONT_EN to compile in continuous scanning.
REQ-026 With MSCAN_CONT_EN defined, ack in DONE SHALL clear valid, set sel=0 and cnt=0 and go directly to SETTLE with busy held at 1; only rst returns the block to IDLE.
REQ-027 Without MSCAN_CONT_EN, behaviour SHALL be exactly as REQ-018, and each scan SHALL need its own start.

Verification
REQ-028 The bench SHALL cover: mux model with I=8'hA5, SETTLE_CYC=2, start pulse -> valid=1 after 24 edges, data=8'hA5, s2..s0 having stepped 0..7.
REQ-029 The bench SHALL cover: valid held with no ack for 10 cycles, then ack -> data stable at 8'hA5 throughout, then valid=0 and busy=0 one edge after ack.
REQ-030 The bench SHALL cover: rst=1 when sel=4 -> next edge gives sel=0, busy=0, valid=0 and data=8'h00, and a following start scans 8'h3C correctly.
REQ-031 The bench SHALL cover: start held high during a scan, plus start together with ack in DONE -> no restart, the block is in IDLE, and valid rises only 24 edges after a later start.
REQ-032 The bench SHALL cover, with MSCAN_CONT_EN: inputs changed from 8'h0F to 8'hF0, ack after the first word -> second valid word 8'hF0 with no start and busy never dropping.
REQ-033 The bench SHALL cover: SETTLE_CYC=1 with I=8'h81 -> valid after 16 edges and data=8'h81.
